// File: rtl/elevator_pkg.sv
// Shared types, sizes and helpers for the 4-floor elevator scheduler.
//   state_t  : controller state (2-bit)
//   dir_t    : last travel direction
//   plan_t   : result of the ahead/behind evaluation (next state + direction)
//   above_mask / below_mask : floors strictly above / below a floor index
//   plan_from: SCAN decision from a floor, direction and pending-call vector
package elevator_pkg;

  localparam int unsigned NUM_FLOORS        = 4;
  localparam int unsigned FLOOR_W           = 2;
  localparam int unsigned TIMER_W           = 8;
  localparam int unsigned DEF_TRAVEL_CYCLES = 8;
  localparam int unsigned DEF_DOOR_CYCLES   = 4;

  typedef logic [NUM_FLOORS-1:0] floor_vec_t;
  typedef logic [FLOOR_W-1:0]    floor_idx_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    state_t st;
    dir_t   dir;
  } plan_t;

  localparam floor_vec_t FLOOR_ONE = floor_vec_t'(1);

  // Floors strictly above f; empty at the top floor.
  function automatic floor_vec_t above_mask(input floor_idx_t f);
    floor_vec_t ones;
    ones = '1;
    return (ones << f) << 1;
  endfunction

  // Floors strictly below f; empty at the ground floor.
  function automatic floor_vec_t below_mask(input floor_idx_t f);
    floor_vec_t ones;
    ones = '1;
    return ~(ones << f);
  endfunction

  // Keep going in the current direction while calls remain ahead, otherwise
  // reverse if anything is behind, otherwise rest. "Ahead" is empty at the
  // end floors, so the car can never be sent past floor 0 or floor 3.
  function automatic plan_t plan_from(input floor_idx_t f, input dir_t d,
                                      input floor_vec_t p);
    logic  any_up;
    logic  any_dn;
    plan_t r;
    any_up = |(p & above_mask(f));
    any_dn = |(p & below_mask(f));
    r.st   = IDLE;
    r.dir  = d;
    if (d == DIR_UP) begin
      if (any_up) begin
        r.st = MOVE_UP;
      end else if (any_dn) begin
        r.st  = MOVE_DOWN;
        r.dir = DIR_DOWN;
      end
    end else begin
      if (any_dn) begin
        r.st = MOVE_DOWN;
      end else if (any_up) begin
        r.st  = MOVE_UP;
        r.dir = DIR_UP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Load / count-down timer shared by the travel and door phases.
//   clk, rst  : clock, synchronous active-high reset (count cleared)
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : cycle count to run
//   done      : high during the last cycle of a loaded interval
module elevator_timer
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  // Loading N gives N cycles in the phase; done marks the Nth.
  assign done = (cnt == TIMER_W'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// Four-floor elevator controller with SCAN call scheduling.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   call_req     : floor call buttons, bit0 = ground .. bit3 = third
//   floor_onehot : current car floor, one-hot
//   pending      : latched calls not yet serviced
//   moving_up    : car travelling up
//   moving_down  : car travelling down
//   door_open    : car stopped with door open
//   busy         : controller not idle or calls pending
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  busy
);

  localparam logic [TIMER_W-1:0] TRAVEL_LD = TIMER_W'(TRAVEL_CYCLES);
  localparam logic [TIMER_W-1:0] DOOR_LD   = TIMER_W'(DOOR_CYCLES);

  state_t             state_q, state_d;
  floor_idx_t         floor_q, floor_d;
  dir_t               dir_q, dir_d;
  floor_vec_t         pend_q, pend_d;

  floor_vec_t         cur_bit;
  floor_idx_t         arr_floor;
  floor_vec_t         arr_bit;
  floor_vec_t         latch;
  floor_vec_t         clr;
  plan_t              plan_here;
  plan_t              plan_arr;
  logic               t_load;
  logic [TIMER_W-1:0] t_val;
  logic               t_done;

  elevator_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    t_load    = 1'b0;
    t_val     = '0;
    clr       = '0;
    cur_bit   = FLOOR_ONE << floor_q;
    arr_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    arr_bit   = FLOOR_ONE << arr_floor;
    plan_here = plan_from(floor_q, dir_q, pend_q);
    plan_arr  = plan_from(arr_floor, dir_q, pend_q);

    // A call for the floor whose door is already open is absorbed by the
    // door restart below instead of being queued.
    latch = call_req;
    if (state_q == DOOR_OPEN) latch = call_req & ~cur_bit;

    unique case (state_q)
      IDLE: begin
        if (|(pend_q & cur_bit)) begin
          state_d = DOOR_OPEN;
          clr     = cur_bit;
          t_load  = 1'b1;
          t_val   = DOOR_LD;
        end else begin
          state_d = plan_here.st;
          dir_d   = plan_here.dir;
          if (plan_here.st != IDLE) begin
            t_load = 1'b1;
            t_val  = TRAVEL_LD;
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (t_done) begin
          floor_d = arr_floor;
          // A call landing on the arrival edge still stops the car here.
          if (|((pend_q | call_req) & arr_bit)) begin
            state_d = DOOR_OPEN;
            clr     = arr_bit;
            t_load  = 1'b1;
            t_val   = DOOR_LD;
          end else begin
            state_d = plan_arr.st;
            dir_d   = plan_arr.dir;
            if (plan_arr.st != IDLE) begin
              t_load = 1'b1;
              t_val  = TRAVEL_LD;
            end
          end
        end
      end
      DOOR_OPEN: begin
        if (|(call_req & cur_bit)) begin
          t_load = 1'b1;
          t_val  = DOOR_LD;
        end else if (t_done) begin
          state_d = plan_here.st;
          dir_d   = plan_here.dir;
          if (plan_here.st != IDLE) begin
            t_load = 1'b1;
            t_val  = TRAVEL_LD;
          end
        end
      end
    endcase

    pend_d = (pend_q | latch) & ~clr;
  end

  // Status outputs are re-registered from the internal state, so they trail
  // it by one cycle as a group; a same-floor call seen while idle therefore
  // shows door_open two edges after it was sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor_onehot <= FLOOR_ONE;
      pending      <= '0;
      moving_up    <= 1'b0;
      moving_down  <= 1'b0;
      door_open    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      floor_onehot <= FLOOR_ONE << floor_q;
      pending      <= pend_q;
      moving_up    <= (state_q == MOVE_UP);
      moving_down  <= (state_q == MOVE_DOWN);
      door_open    <= (state_q == DOOR_OPEN);
      busy         <= (state_q != IDLE) || (pend_q != '0);
    end
  end

endmodule
